ifu_axi_fetch: RTL
==================

Name: ifu_axi_fetch

Overview:
Instruction fetch unit that sits directly upstream of the decode-stage bus register.
- Accepts a fetch request (PC plus valid pulse) from the PC/writeback control.
- Issues a single-beat AXI4-Lite read (AR/R channels) to instruction memory.
- Captures the returned word and presents inst/pc to decode under a valid/ready handshake.
- Exactly one fetch is outstanding at a time.

Parameters:
ADDR_W, 32, width of pc and araddr
DATA_W, 32, width of instruction / rdata
ERR_INST, 32'h0000_0000, instruction word presented when rresp != OKAY

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
pc  input  ADDR_W  fetch address, sampled on s_valid&s_ready
s_valid  input  1  fetch request
s_ready  output  1  fetch request can be accepted this cycle
inst  output  DATA_W  fetched instruction, stable while m_valid
pc_out  output  ADDR_W  address of inst
fetch_err  output  1  rresp was SLVERR/DECERR for this inst
m_valid  output  1  inst/pc_out valid to decode
m_ready  input  1  decode accepts
araddr  output  ADDR_W  AXI read address
arvalid  output  1  AXI AR valid
arready  input  1  AXI AR ready
rdata  input  DATA_W  AXI read data
rresp  input  2  AXI read response
rvalid  input  1  AXI R valid
rready  output  1  AXI R ready

Behaviour:
Reset (rst=1 at posedge, overrides everything):
- state=IDLE.
- arvalid=0, rready=0, m_valid=0, fetch_err=0.
- inst=0, pc_out=0, araddr=0.

State machine, all outputs registered except s_ready:
- IDLE: s_ready=1. On s_valid: latch pc into araddr and pc_out, arvalid<=1, go AR.
- AR: arvalid=1, araddr held stable. On arready: arvalid<=0, rready<=1, go R. arready may already be high in the first AR cycle, giving a 1-cycle AR phase.
- R: rready=1. On rvalid:
  - inst<=(rresp==2'b00)?rdata:ERR_INST
  - fetch_err<=(rresp!=2'b00)
  - rready<=0, m_valid<=1, go HOLD.
- HOLD: m_valid=1; inst/pc_out/fetch_err held. On m_ready:
  - m_valid<=0.
  - If s_valid is also high in the same cycle: latch new pc, arvalid<=1, go AR (back-to-back, no IDLE bubble).
  - Otherwise go IDLE.

s_ready handshake signal:
- s_ready = (state==IDLE) | (state==HOLD & m_ready). Combinational; depends only on state and m_ready, never on s_valid.
- s_valid while s_ready=0 is ignored; the request is not queued. The requester must hold or re-assert it.

Latency:
- Minimum from s_valid accept to m_valid = 3 cycles, with arready=1 and rvalid returned the cycle after rready rises.
- Each cycle of AR or R stall adds one cycle.

AXI rules:
- arvalid, once set, never drops before arready.
- rdata/rresp are sampled only when rvalid&rready.
- rvalid arriving while rready=0 is ignored. The slave is reset by the same rst, so no stray beat is pending after reset.

Decode handshake:
- m_valid, once set, stays high until m_ready.
- inst/pc_out do not change while m_valid=1 & !m_ready.

Boundary conditions:
- Reset asserted during AR or R: abandon the transaction and clear outputs as above; no completion is reported.
- rresp error: still produce one m_valid beat, with fetch_err=1 and inst=ERR_INST.
- pc is not alignment-checked; it is forwarded verbatim.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> arvalid=0, m_valid=0, s_ready=1, inst=0.
- Single fetch, zero-wait slave: s_valid=1, pc=0x8000_0000. Slave gives arready=1 and rdata=0x0000_0413 the cycle after rready -> m_valid=1 exactly 3 cycles after accept, inst=0x0000_0413, pc_out=0x8000_0000, fetch_err=0.
- Stalled slave: arready low for 4 cycles, then rvalid 3 cycles after rready -> araddr stable throughout, m_valid asserted 3+4+2=9 cycles after accept, inst correct.
- Decode backpressure: hold m_ready=0 for 5 cycles after m_valid -> inst/pc_out unchanged, s_ready=0. Then m_ready=1 with s_valid=1, pc=0x8000_0004 -> same cycle s_ready=1, next cycle arvalid=1 with araddr=0x8000_0004.
- Error response: rresp=2'b10, rdata=0xDEAD_BEEF -> m_valid=1, inst=0x0000_0000, fetch_err=1. The next fetch with OKAY clears fetch_err to 0.
- Reset mid-transaction: assert rst while in R (rready=1) -> next cycle rready=0, m_valid=0. An rvalid pulse afterwards produces no m_valid. A new s_valid then fetches normally.

Source files
------------

// File: rtl/ifu_axi_fetch.sv
// Instruction fetch unit: one outstanding single-beat AXI4-Lite read per fetch,
// result presented to decode under a valid/ready handshake.
module ifu_axi_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] ERR_INST = DATA_W'(0)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_err,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              m_valid_q, m_valid_d;
  logic              fetch_err_q, fetch_err_d;

  // Next-state and registered-output logic; s_ready is the only combinational output
  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    pc_out_d    = pc_out_q;
    inst_d      = inst_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    m_valid_d   = m_valid_q;
    fetch_err_d = fetch_err_q;
    s_ready     = 1'b0;

    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          araddr_d  = pc;
          pc_out_d  = pc;
          arvalid_d = 1'b1;
          state_d   = AR;
        end
      end
      AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        if (rvalid) begin
          inst_d      = (rresp == RESP_OKAY) ? rdata : ERR_INST;
          fetch_err_d = (rresp != RESP_OKAY);
          rready_d    = 1'b0;
          m_valid_d   = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        s_ready = m_ready;
        if (m_ready) begin
          m_valid_d = 1'b0;
          // Back-to-back fetch skips the IDLE bubble
          if (s_valid) begin
            araddr_d  = pc;
            pc_out_d  = pc;
            arvalid_d = 1'b1;
            state_d   = AR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      araddr_q    <= '0;
      pc_out_q    <= '0;
      inst_q      <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      pc_out_q    <= pc_out_d;
      inst_q      <= inst_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      m_valid_q   <= m_valid_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign araddr    = araddr_q;
  assign pc_out    = pc_out_q;
  assign inst      = inst_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign m_valid   = m_valid_q;
  assign fetch_err = fetch_err_q;

endmodule
